// File: rtl/axi4_lite_demux.sv
// axi4_lite_demux: 1-to-NUM_SLAVES AXI4-Lite address demux with decode-error responder.
// Define AXI_DEMUX_TIMEOUT_EN to add a per-path response timeout (SLVERR) and IDLE response draining.
module axi4_lite_demux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   up_awaddr_i,
  input  logic                    up_awvalid_i,
  output logic                    up_awready_o,
  input  logic [DATA_WIDTH-1:0]   up_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] up_wstrb_i,
  input  logic                    up_wvalid_i,
  output logic                    up_wready_o,
  output logic                    up_bvalid_o,
  input  logic                    up_bready_i,
  output logic [1:0]              up_bresp_o,
  input  logic [ADDR_WIDTH-1:0]   up_araddr_i,
  input  logic                    up_arvalid_i,
  output logic                    up_arready_o,
  output logic                    up_rvalid_o,
  input  logic                    up_rready_i,
  output logic [DATA_WIDTH-1:0]   up_rdata_o,
  output logic [1:0]              up_rresp_o,
  output logic [ADDR_WIDTH-1:0]   dn_awaddr_o [NUM_SLAVES],
  output logic [NUM_SLAVES-1:0]   dn_awvalid_o,
  input  logic [NUM_SLAVES-1:0]   dn_awready_i,
  output logic [DATA_WIDTH-1:0]   dn_wdata_o [NUM_SLAVES],
  output logic [DATA_WIDTH/8-1:0] dn_wstrb_o [NUM_SLAVES],
  output logic [NUM_SLAVES-1:0]   dn_wvalid_o,
  input  logic [NUM_SLAVES-1:0]   dn_wready_i,
  input  logic [NUM_SLAVES-1:0]   dn_bvalid_i,
  output logic [NUM_SLAVES-1:0]   dn_bready_o,
  input  logic [1:0]              dn_bresp_i [NUM_SLAVES],
  output logic [ADDR_WIDTH-1:0]   dn_araddr_o [NUM_SLAVES],
  output logic [NUM_SLAVES-1:0]   dn_arvalid_o,
  input  logic [NUM_SLAVES-1:0]   dn_arready_i,
  input  logic [NUM_SLAVES-1:0]   dn_rvalid_i,
  output logic [NUM_SLAVES-1:0]   dn_rready_o,
  input  logic [DATA_WIDTH-1:0]   dn_rdata_i [NUM_SLAVES],
  input  logic [1:0]              dn_rresp_i [NUM_SLAVES],
  output logic                    decerr_pulse_o
);
  localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_W:0] NS = (SEL_W + 1)'(NUM_SLAVES);
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP, WR_ERR} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP, RD_ERR} rd_state_e;
  wr_state_e wr_q;
  rd_state_e rd_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic [SEL_W-1:0] wsel_q, wsel_d, rsel_q, rsel_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, wr_slverr_q, rd_slverr_q, decerr_q;
  logic wr_hit, rd_hit, wr_to, rd_to, idle_rdy;
  assign wsel_d = up_awaddr_i[SEL_LSB +: SEL_W];
  assign rsel_d = up_araddr_i[SEL_LSB +: SEL_W];
  assign wr_hit = {1'b0, wsel_d} < NS;
  assign rd_hit = {1'b0, rsel_d} < NS;
  assign up_awready_o = wr_q == WR_IDLE && !rst && up_awvalid_i && up_wvalid_i;
  assign up_wready_o = up_awready_o;
  assign up_arready_o = rd_q == RD_IDLE && !rst && up_arvalid_i;
  assign aw_done_d = aw_done_q | dn_awready_i[wsel_q];
  assign w_done_d = w_done_q | dn_wready_i[wsel_q];
  assign decerr_pulse_o = decerr_q;
`ifdef AXI_DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wr_cnt_q, rd_cnt_q;
  // Timing stops once the selected slave raises its response valid.
  assign wr_to = (wr_q == WR_REQ || (wr_q == WR_RESP && !dn_bvalid_i[wsel_q])) && wr_cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign rd_to = (rd_q == RD_REQ || (rd_q == RD_RESP && !dn_rvalid_i[rsel_q])) && rd_cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign idle_rdy = !rst;
  always_ff @(posedge clk) begin
    wr_cnt_q <= (rst || wr_q == WR_IDLE) ? '0 : wr_cnt_q + 1'b1;
    rd_cnt_q <= (rst || rd_q == RD_IDLE) ? '0 : rd_cnt_q + 1'b1;
  end
`else
  assign wr_to = 1'b0;
  assign rd_to = 1'b0;
  assign idle_rdy = 1'b0 && TIMEOUT_CYCLES > 0;
`endif
  always_comb begin
    dn_awvalid_o = '0;
    dn_wvalid_o = '0;
    dn_arvalid_o = '0;
    dn_bready_o = {NUM_SLAVES{idle_rdy && wr_q == WR_IDLE}};
    dn_rready_o = {NUM_SLAVES{idle_rdy && rd_q == RD_IDLE}};
    dn_awvalid_o[wsel_q] = wr_q == WR_REQ && !aw_done_q;
    dn_wvalid_o[wsel_q] = wr_q == WR_REQ && !w_done_q;
    dn_arvalid_o[rsel_q] = rd_q == RD_REQ;
    if (wr_q == WR_RESP) dn_bready_o[wsel_q] = up_bready_i;
    if (rd_q == RD_RESP) dn_rready_o[rsel_q] = up_rready_i;
    up_bvalid_o = wr_q == WR_ERR || (wr_q == WR_RESP && dn_bvalid_i[wsel_q]);
    up_rvalid_o = rd_q == RD_ERR || (rd_q == RD_RESP && dn_rvalid_i[rsel_q]);
    up_bresp_o = wr_q == WR_ERR ? {1'b1, !wr_slverr_q} : up_bvalid_o ? dn_bresp_i[wsel_q] : 2'b00;
    up_rresp_o = rd_q == RD_ERR ? {1'b1, !rd_slverr_q} : up_rvalid_o ? dn_rresp_i[rsel_q] : 2'b00;
    up_rdata_o = (rd_q == RD_RESP && up_rvalid_o) ? dn_rdata_i[rsel_q] : '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dn_awaddr_o[i] = aw_addr_q;
      dn_wdata_o[i] = w_data_q;
      dn_wstrb_o[i] = w_strb_q;
      dn_araddr_o[i] = ar_addr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      wr_slverr_q <= 1'b0;
      rd_slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else begin
      decerr_q <= (up_awready_o && !wr_hit) || (up_arready_o && !rd_hit);
      case (wr_q)
        WR_IDLE: if (up_awready_o) begin
          aw_addr_q <= up_awaddr_i;
          w_data_q <= up_wdata_i;
          w_strb_q <= up_wstrb_i;
          wsel_q <= wsel_d;
          aw_done_q <= 1'b0;
          w_done_q <= 1'b0;
          wr_slverr_q <= 1'b0;
          wr_q <= wr_hit ? WR_REQ : WR_ERR;
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q <= w_done_d;
          if (aw_done_d && w_done_d) wr_q <= WR_RESP;
        end
        WR_RESP, WR_ERR: if (up_bvalid_o && up_bready_i) wr_q <= WR_IDLE;
      endcase
      if (wr_to) begin
        wr_q <= WR_ERR;
        wr_slverr_q <= 1'b1;
      end
      case (rd_q)
        RD_IDLE: if (up_arready_o) begin
          ar_addr_q <= up_araddr_i;
          rsel_q <= rsel_d;
          rd_slverr_q <= 1'b0;
          rd_q <= rd_hit ? RD_REQ : RD_ERR;
        end
        RD_REQ: if (dn_arready_i[rsel_q]) rd_q <= RD_RESP;
        RD_RESP, RD_ERR: if (up_rvalid_o && up_rready_i) rd_q <= RD_IDLE;
      endcase
      if (rd_to) begin
        rd_q <= RD_ERR;
        rd_slverr_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_demux.sv
// tb_axi4_lite_demux: directed bench for axi4_lite_demux (3 slaves, SEL_LSB 12, timeout 8 when enabled).
module tb_axi4_lite_demux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] up_awaddr, up_araddr;
  logic up_awvalid, up_awready, up_wvalid, up_wready, up_bvalid, up_bready;
  logic up_arvalid, up_arready, up_rvalid, up_rready;
  logic [DW-1:0] up_wdata, up_rdata;
  logic [DW/8-1:0] up_wstrb;
  logic [1:0] up_bresp, up_rresp;
  logic [AW-1:0] dn_awaddr [NS];
  logic [AW-1:0] dn_araddr [NS];
  logic [DW-1:0] dn_wdata [NS];
  logic [DW-1:0] dn_rdata [NS];
  logic [DW/8-1:0] dn_wstrb [NS];
  logic [1:0] dn_bresp [NS];
  logic [1:0] dn_rresp [NS];
  logic [NS-1:0] dn_awvalid, dn_awready, dn_wvalid, dn_wready, dn_bvalid, dn_bready;
  logic [NS-1:0] dn_arvalid, dn_arready, dn_rvalid, dn_rready;
  logic decerr;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  axi4_lite_demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .up_awaddr_i(up_awaddr), .up_awvalid_i(up_awvalid), .up_awready_o(up_awready),
    .up_wdata_i(up_wdata), .up_wstrb_i(up_wstrb), .up_wvalid_i(up_wvalid), .up_wready_o(up_wready),
    .up_bvalid_o(up_bvalid), .up_bready_i(up_bready), .up_bresp_o(up_bresp),
    .up_araddr_i(up_araddr), .up_arvalid_i(up_arvalid), .up_arready_o(up_arready),
    .up_rvalid_o(up_rvalid), .up_rready_i(up_rready), .up_rdata_o(up_rdata), .up_rresp_o(up_rresp),
    .dn_awaddr_o(dn_awaddr), .dn_awvalid_o(dn_awvalid), .dn_awready_i(dn_awready),
    .dn_wdata_o(dn_wdata), .dn_wstrb_o(dn_wstrb), .dn_wvalid_o(dn_wvalid), .dn_wready_i(dn_wready),
    .dn_bvalid_i(dn_bvalid), .dn_bready_o(dn_bready), .dn_bresp_i(dn_bresp),
    .dn_araddr_o(dn_araddr), .dn_arvalid_o(dn_arvalid), .dn_arready_i(dn_arready),
    .dn_rvalid_i(dn_rvalid), .dn_rready_o(dn_rready), .dn_rdata_i(dn_rdata), .dn_rresp_i(dn_rresp),
    .decerr_pulse_o(decerr)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {up_awvalid, up_wvalid, up_bready, up_arvalid, up_rready} = '0;
    up_awaddr = '0; up_araddr = '0; up_wdata = '0; up_wstrb = '0;
    {dn_awready, dn_wready, dn_bvalid, dn_arready, dn_rvalid} = '0;
    for (int i = 0; i < NS; i++) begin
      dn_bresp[i] = 2'b00; dn_rresp[i] = 2'b00; dn_rdata[i] = '0;
    end
    repeat (3) step;
    #1;
    chk("rst_awready", up_awready, 0);
    chk("rst_bvalid", up_bvalid, 0);
    chk("rst_rvalid", up_rvalid, 0);
    chk("rst_dn_valids", {dn_awvalid, dn_wvalid, dn_arvalid}, 0);
    chk("rst_dn_readies", {dn_bready, dn_rready}, 0);
    chk("rst_resp_data", {up_bresp, up_rresp, up_rdata}, 0);
    chk("rst_decerr", decerr, 0);
    rst = 1'b0;
    step;
    // Write to slave 1, slave ready immediately
    up_awaddr = 32'h0000_1004; up_wdata = 32'hDEAD_BEEF; up_wstrb = 4'hF;
    up_awvalid = 1; up_wvalid = 1; up_bready = 1;
    dn_awready[1] = 1; dn_wready[1] = 1;
    #1;
    chk("w1_awready", up_awready, 1);
    chk("w1_wready", up_wready, 1);
    chk("w1_no_dn_yet", dn_awvalid, 0);
    step;
    up_awvalid = 0; up_wvalid = 0;
    #1;
    chk("w1_dn_awvalid", dn_awvalid, 3'b010);
    chk("w1_dn_wvalid", dn_wvalid, 3'b010);
    chk("w1_dn_awaddr", dn_awaddr[1], 32'h0000_1004);
    chk("w1_dn_wdata", dn_wdata[1], 32'hDEAD_BEEF);
    chk("w1_dn_wstrb", dn_wstrb[1], 4'hF);
    step;
    dn_awready[1] = 0; dn_wready[1] = 0;
    dn_bvalid[1] = 1; dn_bresp[1] = 2'b00;
    #1;
    chk("w1_dn_valids_drop", {dn_awvalid, dn_wvalid}, 0);
    chk("w1_bvalid", up_bvalid, 1);
    chk("w1_bresp", up_bresp, 2'b00);
    chk("w1_dn_bready", dn_bready, 3'b010);
    step;
    dn_bvalid[1] = 0; up_bready = 0;
    #1;
    chk("w1_bvalid_done", up_bvalid, 0);
    // Write to slave 2, W accepted 3 cycles before AW
    up_awaddr = 32'h0000_2000; up_wdata = 32'h1234_5678; up_wstrb = 4'h3;
    up_awvalid = 1; up_wvalid = 1; dn_wready[2] = 1;
    step;
    up_awvalid = 0; up_wvalid = 0;
    #1;
    chk("w2_dn_awvalid", dn_awvalid, 3'b100);
    chk("w2_dn_wvalid", dn_wvalid, 3'b100);
    step;
    dn_wready[2] = 0;
    #1;
    chk("w2_w_done", dn_wvalid, 3'b000);
    chk("w2_aw_pending", dn_awvalid, 3'b100);
    step;
    step;
    dn_awready[2] = 1;
    step;
    dn_awready[2] = 0;
    #1;
    chk("w2_aw_done", dn_awvalid, 3'b000);
    chk("w2_no_b_yet", up_bvalid, 0);
    dn_bvalid[2] = 1; dn_bresp[2] = 2'b10;
    #1;
    chk("w2_bvalid", up_bvalid, 1);
    chk("w2_bresp", up_bresp, 2'b10);
    chk("w2_bready_low", dn_bready, 3'b000);
    step;
    up_bready = 1;
    #1;
    chk("w2_bready_pass", dn_bready, 3'b100);
    step;
    dn_bvalid[2] = 0; up_bready = 0;
    #1;
    chk("w2_idle_bvalid", up_bvalid, 0);
    chk("w2_idle_bresp", up_bresp, 2'b00);
    // Read decode miss (index 3)
    up_araddr = 32'h0000_3010; up_arvalid = 1;
    #1;
    chk("miss_arready", up_arready, 1);
    step;
    up_arvalid = 0;
    #1;
    chk("miss_rvalid", up_rvalid, 1);
    chk("miss_rresp", up_rresp, 2'b11);
    chk("miss_rdata", up_rdata, 0);
    chk("miss_decerr", decerr, 1);
    chk("miss_no_dn", dn_arvalid, 0);
    step;
    #1;
    chk("miss_decerr_pulse", decerr, 0);
    chk("miss_rvalid_hold", up_rvalid, 1);
    up_rready = 1;
    step;
    up_rready = 0;
    #1;
    chk("miss_done", up_rvalid, 0);
    // Concurrent write to slave 0 and read from slave 1
    up_awaddr = 32'h0000_0008; up_wdata = 32'h0BAD_F00D; up_wstrb = 4'hC;
    up_araddr = 32'h0000_1010;
    up_awvalid = 1; up_wvalid = 1; up_arvalid = 1;
    dn_awready[0] = 1; dn_wready[0] = 1; dn_arready[1] = 1;
    step;
    up_awvalid = 0; up_wvalid = 0; up_arvalid = 0;
    #1;
    chk("cc_dn_awvalid", dn_awvalid, 3'b001);
    chk("cc_dn_arvalid", dn_arvalid, 3'b010);
    chk("cc_dn_araddr", dn_araddr[1], 32'h0000_1010);
    step;
    dn_awready[0] = 0; dn_wready[0] = 0; dn_arready[1] = 0;
    dn_bvalid[0] = 1; dn_bresp[0] = 2'b00;
    dn_rvalid[1] = 1; dn_rdata[1] = 32'hCAFE_F00D; dn_rresp[1] = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("cc_hold", {up_bvalid, up_rvalid, up_bresp, up_rresp, up_rdata}, {1'b1, 1'b1, 2'b00, 2'b01, 32'hCAFE_F00D});
      step;
    end
    up_bready = 1;
    #1;
    chk("cc_bready", {dn_bready, dn_rready}, {3'b001, 3'b000});
    step;
    dn_bvalid[0] = 0; up_bready = 0;
    #1;
    chk("cc_b_done", {up_bvalid, up_rvalid}, 2'b01);
    up_rready = 1;
    step;
    dn_rvalid[1] = 0; up_rready = 0;
    #1;
    chk("cc_r_done", {up_rvalid, up_rdata}, 0);
    // AWVALID without WVALID, then reset mid-request
    up_awaddr = 32'h0000_0000; up_awvalid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("aw_only_ready", {up_awready, up_wready}, 2'b00);
      step;
    end
    up_wvalid = 1;
    #1;
    chk("aw_w_ready", {up_awready, up_wready}, 2'b11);
    step;
    up_awvalid = 0; up_wvalid = 0;
    #1;
    chk("rq_dn_awvalid", dn_awvalid, 3'b001);
    rst = 1;
    step;
    #1;
    chk("rq_rst_dn", {dn_awvalid, dn_wvalid, dn_arvalid, dn_bready, dn_rready}, 0);
    chk("rq_rst_up", {up_bvalid, up_rvalid, up_awready, decerr}, 0);
    rst = 0;
    step;
`ifdef AXI_DEMUX_TIMEOUT_EN
    up_awaddr = 32'h0000_0040; up_awvalid = 1; up_wvalid = 1;
    dn_awready[0] = 1; dn_wready[0] = 1;
    step;
    up_awvalid = 0; up_wvalid = 0;
    for (int k = 0; k < 7; k++) begin
      step;
      chk("to_wait", up_bvalid, 0);
    end
    step;
    chk("to_bvalid", up_bvalid, 1);
    chk("to_bresp", up_bresp, 2'b10);
    chk("to_no_decerr", decerr, 0);
    chk("to_dn_quiet", {dn_awvalid, dn_wvalid}, 0);
    up_bready = 1;
    step;
    up_bready = 0; dn_bvalid[0] = 1;
    #1;
    chk("to_drain", {dn_bready, dn_rready}, 6'b111111);
    step;
    dn_bvalid[0] = 0;
`else
    dn_bvalid[0] = 1;
    #1;
    chk("idle_no_drain", {dn_bready, up_bvalid}, 0);
    step;
    dn_bvalid[0] = 0;
`endif
    step;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_lite_demux.md
Name:
axi4_lite_demux

Overview:
Parametrised 1-to-NUM_SLAVES AXI4-Lite address demultiplexer with a built-in decode-error responder. It sits between one axi4_lite_if master (core data port) and an array of axi4_lite_if slaves (RAM, UART, timer, ...). Read and write paths are independent, and each path allows one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, address width of all interfaces
DATA_WIDTH, 32, data width of all interfaces; WSTRB is DATA_WIDTH/8
NUM_SLAVES, 4, downstream slave count, 1..16; SEL_W = max(1, $clog2(NUM_SLAVES))
SEL_LSB, 12, slave index = addr[SEL_LSB +: SEL_W]; an index >= NUM_SLAVES is a decode miss
TIMEOUT_CYCLES, 256, response timeout; used only with AXI_DEMUX_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
up  axi4_lite_if (slave side)  ADDR_WIDTH/DATA_WIDTH  upstream port facing the master
dn  axi4_lite_if [NUM_SLAVES] (master side)  ADDR_WIDTH/DATA_WIDTH  downstream ports; dn[i] serves index i
decerr_pulse  output  1  one-cycle pulse on entry to WR_ERR or RD_ERR

Behaviour:
- Reset: both FSMs return to IDLE and done flags clear. All up.*VALID/up.*READY, all dn[*].*VALID/*READY, up.BRESP, up.RRESP, up.RDATA and decerr_pulse are 0. A reset mid-transaction abandons it; the bench resets the slaves too.
- Write FSM states: WR_IDLE, WR_REQ, WR_RESP, WR_ERR.
- WR_IDLE:
  - up.AWREADY = up.WREADY = up.AWVALID & up.WVALID (combinational), so AW and W are accepted in the same cycle only.
  - On accept: latch AWADDR, WDATA, WSTRB and decoded sel.
  - Next state: WR_REQ on a hit, WR_ERR on a miss.
- WR_REQ:
  - dn[sel].AWVALID = ~aw_done and dn[sel].WVALID = ~w_done. Both are first high the cycle after upstream accept.
  - Each done flag sets on its dn handshake; both flags clear on entry.
  - Once both are done (same-cycle completion allowed): go to WR_RESP.
- WR_RESP:
  - Combinational passthrough: up.BVALID = dn[sel].BVALID, up.BRESP = dn[sel].BRESP, dn[sel].BREADY = up.BREADY.
  - Upstream B handshake: go to WR_IDLE.
- WR_ERR: up.BVALID = 1, up.BRESP = 2'b11 (DECERR); no dn activity; up B handshake: go to WR_IDLE.
- Read FSM (RD_IDLE, RD_REQ, RD_RESP, RD_ERR) mirrors the write FSM:
  - up.ARREADY = up.ARVALID in RD_IDLE.
  - dn[sel].ARVALID is held until dn ARREADY.
  - RDATA/RRESP/RVALID/RREADY pass through in RD_RESP.
  - RD_ERR: up.RDATA = 0, up.RRESP = 2'b11.
- Unselected dn[i]: all VALID/READY = 0. Address/data buses carry the latched values (don't-care).
- up.BRESP/up.RRESP/up.RDATA are 0 whenever the matching up VALID is 0.
- Read and write run concurrently, including to the same slave; no ordering between them.
- Latency: upstream accept to dn VALID = 1 cycle; dn response to up response = 0 cycles.
- Decode miss to up.BVALID/RVALID = 1 cycle; decerr_pulse is high in that same cycle.

Optional Feature:
AXI_DEMUX_TIMEOUT_EN
- Enabled: a per-path counter clears on entry to REQ. If dn[sel] has not raised BVALID/RVALID TIMEOUT_CYCLES cycles after entry, the path:
  - drops its dn VALIDs;
  - enters ERR with response 2'b10 (SLVERR), RDATA 0;
  - does not assert decerr_pulse.
- Enabled, IDLE: all dn[*].BREADY/RREADY = 1 to drain late responses.
- Disabled: the path waits indefinitely, TIMEOUT_CYCLES is unused, and dn READYs are 0 in IDLE.

Test Plan:
NUM_SLAVES=3, SEL_LSB=12:
- Write 0x0000_1004, data 0xDEADBEEF, strb 0xF, slave1 ready immediately:
  - dn[1].AWVALID/WVALID high 1 cycle after accept;
  - up.BRESP=0 on slave1 BVALID;
  - dn[0]/dn[2] valids stay 0.
- Write, slave2 accepts W 3 cycles before AW (addr 0x2000): single dn[2] B forwarded; FSM back to WR_IDLE after up.BREADY.
- Read 0x0000_3010 (index 3, miss) -> up.RVALID the next cycle, RRESP=2'b11, RDATA=0, decerr_pulse 1 cycle; no dn ARVALID.
- Concurrent write to slave0 and read from slave1, up.BREADY/up.RREADY held low 5 cycles -> responses held stable, then both complete independently.
- up.AWVALID without up.WVALID for 4 cycles -> AWREADY stays 0; WVALID rises -> AWREADY and WREADY both high that cycle.
- Timeout build, TIMEOUT_CYCLES=8, slave0 never responds -> up.BRESP=2'b10 after 8 cycles, no decerr_pulse; a late slave0 BVALID is drained in IDLE. Also assert rst during WR_REQ -> all outputs 0 next cycle.
